sp_ram_be: RTL
==============

# sp_ram_be

Parametrised single-port synchronous RAM with per-byte write enables, a registered read port with valid strobe, and a selectable read-during-write mode. It clears itself to a programmable value after reset or on request, using a sweep state machine. It is the general-purpose successor of the team's fixed 8x64 single-port RAM, used wherever a small scratch or buffer memory sits behind a request/valid interface.

## Interface
Parameters:
- DATA_W, 8, word width in bits; must be a multiple of 8.
- ADDR_W, 6, address width.
- DEPTH, 1<<ADDR_W, number of words; 1 ≤ DEPTH ≤ 2^ADDR_W.
- RDW_MODE, 0, read-during-write behaviour: 0 = read-first, 1 = write-first, 2 = no-change.
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sweep.

Ports:
- clk, in, 1, clock; all logic is on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- clr, in, 1, start a clear sweep (single-cycle pulse).
- req, in, 1, access request, valid only while ready=1.
- we, in, 1, 1 = write, 0 = read; qualified by req.
- be, in, DATA_W/8, byte enables for writes; bit i covers wdata[8i+7:8i].
- addr, in, ADDR_W, word address.
- wdata, in, DATA_W, write data.
- rdata, out, DATA_W, registered read data.
- rvalid, out, 1, one-cycle strobe indicating rdata was updated.
- ready, out, 1, 1 = accepting requests, 0 = clear sweep in progress.

## Operation
- **States.** CLEAR (sweep) and READY. A registered counter clr_cnt (ADDR_W bits) tracks sweep progress.
- **rst=1.**
  - state=CLEAR, clr_cnt=0.
  - Outputs: rdata=0, rvalid=0, ready=0.
  - No memory write occurs while rst=1.
  - Reset is honoured mid-sweep and mid-access. A write coinciding with rst=1 is dropped.
- **CLEAR.**
  - Each edge writes INIT_VAL to mem[clr_cnt] (all bytes) and increments clr_cnt.
  - When clr_cnt==DEPTH-1, that word is written and the block moves to READY.
  - req is ignored. rvalid=0. rdata holds its value.
- **READY.** ready=1.
  - **Write** (req=1, we=1): for each i with be[i]=1, the byte is written at the edge. Bytes with be[i]=0 are untouched. be=0 is a no-op write.
  - **Read** (req=1, we=0): at the edge, rdata←mem[addr] and rvalid←1.
  - **Write cycle, rdata/rvalid by RDW_MODE:**
    - 0: rdata←old word, rvalid←1.
    - 1: rdata←merged new word (old bytes where be=0), rvalid←1.
    - 2: rdata holds, rvalid←0.
  - **req=0:** rvalid←0, rdata holds.
- **clr.**
  - Sampled high in READY: enter CLEAR, clr_cnt=0. A req in the same cycle is ignored (clr wins).
  - Sampled high in CLEAR: restart the sweep from 0.
  - rst has priority over clr.
- **Out-of-range address** (addr ≥ DEPTH, only possible when DEPTH < 2^ADDR_W):
  - Write is dropped.
  - Read returns rdata=0 with rvalid=1.
  - A write-first write returns 0.
- No concurrent access exists: there is a single port, one operation per cycle.

## Timing
- **Read latency:** 1 cycle. A request sampled at edge N gives rdata/rvalid valid after edge N and stable until edge N+1.
- rvalid is high for exactly one cycle per accepted read, or per write in modes 0 and 1.
- **Write visibility:** a read issued in the cycle after a write to the same address returns the new data.
- **Sweep length:** exactly DEPTH edges. If rst is low from edge E1 onward, the writes happen at E1..E_DEPTH and ready=1 after E_DEPTH.
- **clr sampled at edge N in READY:** ready=0 after N. The sweep writes happen at edges N+1..N+DEPTH, and ready=1 after edge N+DEPTH.
- ready is registered and free of glitches. Requests with ready=0 have no side effects.

## Test plan
- **Reset sweep.** Defaults, INIT_VAL=8'hA5. Hold rst 3 cycles, then release. ready rises exactly 64 cycles later. Reads of addresses 0, 31 and 63 then return A5 with rvalid=1 one cycle after each request.
- **Byte enables.** DATA_W=32.
  - Write 32'h11223344 with be=4'hF to addr 5.
  - Write 32'hAABBCCDD with be=4'b0101 to addr 5.
  - Read addr 5 → 32'h11BB33DD.
- **RDW modes.** mem[9]=8'h3C, then write 8'hC3 to addr 9:
  - RDW_MODE=0: rdata=3C, rvalid=1.
  - RDW_MODE=1: rdata=C3, rvalid=1.
  - RDW_MODE=2: rdata unchanged, rvalid=0.
  - In all modes, a following read returns C3.
- **clr vs req.**
  - Assert clr and a write to addr 2 in the same cycle. The write is dropped, ready=0 for 64 cycles, and addr 2 reads INIT_VAL afterwards.
  - Pulse clr at sweep count 20. ready rises 64 cycles after the second pulse.
- **Reset mid-operation.**
  - Assert rst at sweep count 40. Outputs are 0 the next cycle and the sweep restarts at 0.
  - Assert rst together with a write in READY. The write is not performed.
- **Partial depth.** DEPTH=48, ADDR_W=6.
  - The sweep takes 48 cycles.
  - Write 8'h77 to addr 50, then read addr 50 → rdata=0, rvalid=1.
  - Addr 47 is written and read back normally.

Source files
------------

// File: rtl/sp_ram_be.sv
`default_nettype none
// ============================================================================
//  Module   : sp_ram_be
//  Purpose  : Parametrised single-port synchronous RAM with per-byte write
//             enables, a registered read port with a one-cycle valid strobe
//             and a selectable read-during-write mode. After reset, or on a
//             clr pulse, a sweep state machine writes INIT_VAL to every word
//             before the port accepts requests again.
//  Ports    : clk_i    - clock, all logic on the rising edge
//             rst_i    - synchronous active-high reset
//             clr_i    - start (or restart) a clear sweep
//             req_i    - access request, honoured only while ready_o=1
//             we_i     - 1 = write, 0 = read
//             be_i     - byte enables for writes (bit i -> wdata_i[8i+7:8i])
//             addr_i   - word address
//             wdata_i  - write data
//             rdata_o  - registered read data
//             rvalid_o - one-cycle strobe, rdata_o was updated
//             ready_o  - 1 = accepting requests, 0 = clear sweep running
//  Revision : 1.0 - initial release
// ============================================================================
module sp_ram_be #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 6,
   parameter int                DEPTH    = 1 << ADDR_W,
   parameter int                RDW_MODE = 0,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [DATA_W/8-1:0]   be_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o,
   output logic                  rvalid_o,
   output logic                  ready_o
);

   localparam int                NUM_BYTES = DATA_W / 8;
   localparam logic [0:0]        ST_CLEAR  = 1'b0;
   localparam logic [0:0]        ST_READY  = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   // -------------------------------------------------------------------------
   // Storage and state
   // -------------------------------------------------------------------------
   logic [DATA_W-1:0]    mem [DEPTH];

   logic [0:0]           state_q;
   logic [0:0]           state_d;
   logic [ADDR_W-1:0]    clr_cnt_q;
   logic [ADDR_W-1:0]    clr_cnt_d;
   logic [DATA_W-1:0]    rdata_q;
   logic                 rvalid_q;

   // FSM outputs / datapath controls
   logic                 w_sweep;
   logic                 w_acc;
   logic                 w_wr;
   logic                 w_rd;
   logic [NUM_BYTES-1:0] w_mem_be;
   logic [ADDR_W-1:0]    w_mem_addr;
   logic [DATA_W-1:0]    w_mem_wdata;

   // Datapath
   logic                 w_in_range;
   logic [DATA_W-1:0]    w_old;
   logic [DATA_W-1:0]    w_merged;
   logic [DATA_W-1:0]    w_wr_rdata;
   logic                 w_wr_rvalid;

   // -------------------------------------------------------------------------
   // Address range check: only a partial-depth memory can be addressed past
   // its last word, so the comparator exists only in that configuration.
   // -------------------------------------------------------------------------
   generate
      if (DEPTH == (1 << ADDR_W)) begin : g_full_depth
         assign w_in_range = 1'b1;
      end else begin : g_part_depth
         assign w_in_range = ({1'b0, addr_i} < (ADDR_W + 1)'(DEPTH));
      end
   endgenerate

   // Out-of-range locations read as zero.
   assign w_old = w_in_range ? mem[addr_i] : '0;

   // Word as it will look after the write: new bytes where enabled.
   generate
      for (genvar b = 0; b < NUM_BYTES; b++) begin : g_merge
         assign w_merged[8*b +: 8] = be_i[b] ? wdata_i[8*b +: 8] : w_old[8*b +: 8];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Read-during-write result selection
   // -------------------------------------------------------------------------
   generate
      if (RDW_MODE == 1) begin : g_rdw_write_first
         // A dropped out-of-range write reports zero, not the discarded data.
         assign w_wr_rdata  = w_in_range ? w_merged : '0;
         assign w_wr_rvalid = 1'b1;
      end else if (RDW_MODE == 2) begin : g_rdw_no_change
         assign w_wr_rdata  = rdata_q;
         assign w_wr_rvalid = 1'b0;
      end else begin : g_rdw_read_first
         assign w_wr_rdata  = w_old;
         assign w_wr_rvalid = 1'b1;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (clr_i) begin
               clr_cnt_d = '0;
            end else if (clr_cnt_q == LAST_ADDR) begin
               state_d   = ST_READY;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         ST_READY: begin
            if (clr_i) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: output logic (access qualification and memory write port)
   // -------------------------------------------------------------------------
   always_comb begin
      w_sweep     = (state_q == ST_CLEAR);
      // clr in the same cycle as a request wins; the request is discarded.
      w_acc       = (state_q == ST_READY) && req_i && !clr_i;
      w_wr        = w_acc && we_i;
      w_rd        = w_acc && !we_i;
      w_mem_be    = '0;
      w_mem_addr  = addr_i;
      w_mem_wdata = wdata_i;
      if (!rst_i) begin
         if (w_sweep) begin
            w_mem_be    = '1;
            w_mem_addr  = clr_cnt_q;
            w_mem_wdata = INIT_VAL;
         end else if (w_wr && w_in_range) begin
            w_mem_be    = be_i;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Memory array (no reset; contents are established by the sweep)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (w_mem_be[b]) begin
            mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Registered read port
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else if (w_rd) begin
         rdata_q  <= w_old;
         rvalid_q <= 1'b1;
      end else if (w_wr) begin
         rdata_q  <= w_wr_rdata;
         rvalid_q <= w_wr_rvalid;
      end else begin
         rvalid_q <= 1'b0;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign ready_o  = (state_q == ST_READY);

endmodule
`default_nettype wire
